// File: rtl/gpu_seq_pkg.sv
// Shared types and constants for the GPU APB command sequencer.
// Opcodes, FSM state encodings, command entry layout, APB constants.
package gpu_seq_pkg;

  localparam int SEQ_ADDR_W = 32;
  localparam int SEQ_DATA_W = 32;
  localparam int SEQ_OP_W   = 2;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'd0,
    OP_DELAY     = 2'd1,
    OP_WAIT_IDLE = 2'd2,
    OP_CLR_CNT   = 2'd3
  } seq_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DELAY  = 3'd3,
    ST_WAIT   = 3'd4
  } seq_state_t;

  typedef struct packed {
    seq_op_t                 op;
    logic [SEQ_ADDR_W-1:0]   addr;
    logic [SEQ_DATA_W-1:0]   data;
  } seq_cmd_t;

  // APB direction encodings shared with gpu_definitions
  localparam logic APB_READ  = 1'b0;
  localparam logic APB_WRITE = 1'b1;

endpackage

// File: rtl/gpu_apb_sequencer_if.sv
// Command push port and APB master bus of the sequencer.
// master: sequencer side; slave: command source / APB slave side.
interface gpu_apb_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid_i;
  logic [1:0]        cmd_op_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_data_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] pAddr_o;
  logic [DATA_W-1:0] pDataWrite_o;
  logic              pSel_o;
  logic              pEnable_o;
  logic              pWrite_o;
  logic              pReady_i;

  modport master (
    input  cmd_valid_i, cmd_op_i,
    input  cmd_addr_i, cmd_data_i,
    input  pReady_i,
    output cmd_ready_o,
    output pAddr_o, pDataWrite_o,
    output pSel_o, pEnable_o, pWrite_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i,
    output cmd_addr_i, cmd_data_i,
    output pReady_i,
    input  cmd_ready_o,
    input  pAddr_o, pDataWrite_o,
    input  pSel_o, pEnable_o, pWrite_o
  );
endinterface

// File: rtl/gpu_seq_fifo.sv
// Synchronous command FIFO; push/pop/wdata in, head/full/empty/level out.
// Level is registered, so a pop never raises ready in the same cycle.
module gpu_seq_fifo #(
  parameter  int W     = 66,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + AW'(1);
    if (do_pop)  rp_d = rp_q + AW'(1);
    if (do_push && !do_pop)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop && !do_push)
      cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rp_q];
  assign full_o  = (cnt_q == FULL);
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
endmodule

// File: rtl/gpu_apb_sequencer.sv
// Replays queued GPU commands as APB writes, delays and idle waits.
// Ports: clk/rst, bus (cmd push + APB master), data_avail_i, pix/busy/level.
module gpu_apb_sequencer
  import gpu_seq_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int DEPTH       = 16,
  parameter  int IDLE_CYCLES = 16,
  parameter  int PIX_CNT_W   = 20,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gpu_apb_sequencer_if.master  bus,
  input  logic                 data_avail_i,
  output logic [PIX_CNT_W-1:0] pix_count_o,
  output logic                 busy_o,
  output logic [LW-1:0]        level_o
);
  localparam int W = 2 + ADDR_W + DATA_W;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_SETUP  = ST_SETUP;
  localparam logic [2:0] S_ACCESS = ST_ACCESS;
  localparam logic [2:0] S_DELAY  = ST_DELAY;
  localparam logic [2:0] S_WAIT   = ST_WAIT;

  localparam logic [DATA_W-1:0] IDLE_N =
    DATA_W'(IDLE_CYCLES);

  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 psel_q, psel_d;
  logic                 pen_q, pen_d;
  logic [DATA_W-1:0]    dly_q, dly_d;
  logic [DATA_W-1:0]    idle_q, idle_d;
  logic [DATA_W-1:0]    idle_inc;
  logic [PIX_CNT_W-1:0] pix_q, pix_d;

  logic [W-1:0]         head;
  seq_op_t              head_op;
  logic [ADDR_W-1:0]    head_addr;
  logic [DATA_W-1:0]    head_data;
  logic                 full, empty, pop, clr;

  gpu_seq_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.cmd_valid_i),
    .wdata_i ({bus.cmd_op_i, bus.cmd_addr_i,
               bus.cmd_data_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign head_op   = seq_op_t'(head[W-1 -: 2]);
  assign head_addr = head[DATA_W +: ADDR_W];
  assign head_data = head[DATA_W-1:0];

  assign pop      = (state_q == S_IDLE) & ~empty;
  assign clr      = pop & (head_op == OP_CLR_CNT);
  assign idle_inc = idle_q + DATA_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    psel_d  = psel_q;
    pen_d   = pen_q;
    dly_d   = dly_q;
    idle_d  = idle_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (pop) begin
          unique case (head_op)
            OP_WRITE: begin
              state_d = S_SETUP;
              addr_d  = head_addr;
              data_d  = head_data;
              psel_d  = 1'b1;
            end
            OP_DELAY: begin
              state_d = S_DELAY;
              dly_d   = head_data;
            end
            OP_WAIT_IDLE: begin
              state_d = S_WAIT;
              idle_d  = '0;
            end
            OP_CLR_CNT: ;
          endcase
        end
      end
      state_q == S_SETUP: begin
        pen_d   = 1'b1;
        state_d = S_ACCESS;
      end
      state_q == S_ACCESS: begin
        if (bus.pReady_i) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      state_q == S_DELAY: begin
        if (dly_q == '0) state_d = S_IDLE;
        else dly_d = dly_q - DATA_W'(1);
      end
      state_q == S_WAIT: begin
        if (data_avail_i) begin
          idle_d = '0;
        end else begin
          idle_d = idle_inc;
          if (idle_inc == IDLE_N) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // clear beats a coincident pixel strobe
  always_comb begin
    pix_d = pix_q;
    if (clr)
      pix_d = '0;
    else if (data_avail_i && pix_q != '1)
      pix_d = pix_q + PIX_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      psel_q  <= 1'b0;
      pen_q   <= 1'b0;
      dly_q   <= '0;
      idle_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      psel_q  <= psel_d;
      pen_q   <= pen_d;
      dly_q   <= dly_d;
      idle_q  <= idle_d;
      pix_q   <= pix_d;
    end
  end

  assign bus.cmd_ready_o  = ~full;
  assign bus.pAddr_o      = addr_q;
  assign bus.pDataWrite_o = data_q;
  assign bus.pSel_o       = psel_q;
  assign bus.pEnable_o    = pen_q;
  assign bus.pWrite_o     = psel_q;
  assign pix_count_o      = pix_q;
  assign busy_o           = (state_q != S_IDLE) | ~empty;
endmodule

// File: tb/tb_gpu_apb_sequencer.sv
// Directed bench for gpu_apb_sequencer with a transaction-level model.
// Compares every cycle on negedge, plus literal spot checks.
module tb_gpu_apb_sequencer;
  localparam int DEPTH   = 16;
  localparam int IDLE_N  = 16;
  localparam int PIX_W   = 6;
  localparam int PIX_MAX = 63;

  localparam logic [1:0] OW = 2'd0;
  localparam logic [1:0] OD = 2'd1;
  localparam logic [1:0] OI = 2'd2;
  localparam logic [1:0] OC = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             data_avail = 1'b0;
  logic [PIX_W-1:0] pix;
  logic             busy;
  logic [4:0]       level;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  gpu_apb_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus();

  gpu_apb_sequencer #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .IDLE_CYCLES(IDLE_N), .PIX_CNT_W(PIX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .data_avail_i (data_avail),
    .pix_count_o  (pix),
    .busy_o       (busy),
    .level_o      (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef enum int {A_NONE, A_WR, A_DLY, A_WT} act_t;

  cmd_t        q[$];
  cmd_t        c;
  act_t        act = A_NONE;
  int          t = 0;
  int          run = 0;
  longint      cur_d = 0;
  int          m_pix = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          sz;
  bit          clr;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      act = A_NONE; t = 0; run = 0;
      m_pix = 0; m_addr = '0; m_data = '0;
    end else begin
      sz  = q.size();
      clr = 0;
      if (act == A_WR) begin
        if (t >= 1 && bus.pReady_i) act = A_NONE;
        else t++;
      end else if (act == A_DLY) begin
        if (t == cur_d) act = A_NONE;
        else t++;
      end else if (act == A_WT) begin
        run = data_avail ? 0 : run + 1;
        if (run == IDLE_N) act = A_NONE;
      end else if (sz != 0) begin
        c = q.pop_front();
        case (c.op)
          OW: begin
            act = A_WR; t = 0;
            m_addr = c.addr; m_data = c.data;
          end
          OD: begin act = A_DLY; t = 0; cur_d = c.data; end
          OI: begin act = A_WT; run = 0; end
          default: clr = 1;
        endcase
      end
      if (clr) m_pix = 0;
      else if (data_avail && m_pix < PIX_MAX) m_pix++;
      if (bus.cmd_valid_i && sz < DEPTH)
        q.push_back('{bus.cmd_op_i, bus.cmd_addr_i,
                      bus.cmd_data_i});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pSel", bus.pSel_o, act == A_WR);
      check("pEnable", bus.pEnable_o,
            act == A_WR && t >= 1);
      check("pWrite", bus.pWrite_o, act == A_WR);
      check("pAddr", bus.pAddr_o, m_addr);
      check("pData", bus.pDataWrite_o, m_data);
      check("ready", bus.cmd_ready_o, q.size() < DEPTH);
      check("level", level, q.size());
      check("busy", busy,
            act != A_NONE || q.size() != 0);
      check("pix", pix, m_pix);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] d);
    bit acc;
    int g;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = a;
    bus.cmd_data_i  = d;
    g = 0;
    do begin
      acc = bus.cmd_ready_o;
      step(1);
      g++;
    end while (!acc && g < 300);
    if (!acc) check("push_timeout", 0, 1);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (busy && g < 1000) begin
      step(1);
      g++;
    end
    check("drain_timeout", busy, 0);
  endtask

  task automatic wait_pen();
    int g = 0;
    while (!bus.pEnable_o && g < 50) begin
      step(1);
      g++;
    end
    check("pen_timeout", bus.pEnable_o, 1);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 2'd0;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.pReady_i    = 1'b1;
    step(2);
    chk_en = 1;
    check("rst_psel", bus.pSel_o, 0);
    check("rst_level", level, 0);
    check("rst_ready", bus.cmd_ready_o, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // single zero-wait write
    push(OW, 32'h4, 32'h00FF00FF);
    check("w1_pre_psel", bus.pSel_o, 0);
    check("w1_level", level, 1);
    step(1);
    check("w1_psel", bus.pSel_o, 1);
    check("w1_pen0", bus.pEnable_o, 0);
    check("w1_addr", bus.pAddr_o, 32'h4);
    check("w1_data", bus.pDataWrite_o, 32'h00FF00FF);
    step(1);
    check("w1_pen1", bus.pEnable_o, 1);
    step(1);
    check("w1_done", bus.pSel_o, 0);
    check("w1_hold", bus.pAddr_o, 32'h4);

    // wait-stated write followed by a queued one
    bus.pReady_i = 1'b0;
    push(OW, 32'h8, 32'h1234);
    push(OW, 32'hC, 32'h5678);
    step(1);
    for (int i = 0; i < 4; i++) begin
      check("ws_pen", bus.pEnable_o, 1);
      check("ws_addr", bus.pAddr_o, 32'h8);
      check("ws_data", bus.pDataWrite_o, 32'h1234);
      if (i < 3) step(1);
    end
    bus.pReady_i = 1'b1;
    step(1);
    check("ws_end", bus.pSel_o, 0);
    drain();

    // fill the FIFO behind a stalled transfer
    bus.pReady_i = 1'b0;
    for (int i = 0; i < 17; i++)
      push(OW, 32'h100 + 32'(i * 4), 32'(i));
    check("full_level", level, 16);
    check("full_ready", bus.cmd_ready_o, 0);
    fork
      push(OW, 32'h200, 32'hBEEF);
      begin
        step(3);
        check("held_level", level, 16);
        check("held_ready", bus.cmd_ready_o, 0);
        bus.pReady_i = 1'b1;
      end
    join
    drain();

    // wait-idle with a two-cycle pixel burst
    push(OI, 32'h0, 32'h0);
    step(11);
    data_avail = 1'b1;
    step(2);
    data_avail = 1'b0;
    step(15);
    check("wi_busy", busy, 1);
    step(1);
    check("wi_exit", busy, 0);
    check("wi_pix", pix, 2);

    // delay 5 then write
    push(OD, 32'h0, 32'd5);
    push(OW, 32'h20, 32'hAA);
    step(6);
    check("d5_psel0", bus.pSel_o, 0);
    check("d5_busy", busy, 1);
    step(1);
    check("d5_psel1", bus.pSel_o, 1);
    drain();

    // delay 0 then write
    push(OD, 32'h0, 32'd0);
    push(OW, 32'h24, 32'hBB);
    step(1);
    check("d0_psel0", bus.pSel_o, 0);
    step(1);
    check("d0_psel1", bus.pSel_o, 1);
    drain();

    // saturation, then clear against a live strobe
    data_avail = 1'b1;
    step(70);
    check("pix_sat", pix, 63);
    push(OC, 32'h0, 32'h0);
    step(1);
    check("clr_wins", pix, 0);
    step(3);
    check("pix_3", pix, 3);
    data_avail = 1'b0;

    // reset in ACCESS with three queued
    bus.pReady_i = 1'b0;
    for (int i = 0; i < 4; i++)
      push(OW, 32'h300 + 32'(i), 32'(i));
    wait_pen();
    rst = 1'b1;
    step(1);
    check("ra_psel", bus.pSel_o, 0);
    check("ra_pen", bus.pEnable_o, 0);
    check("ra_level", level, 0);
    check("ra_pix", pix, 0);
    check("ra_busy", busy, 0);
    check("ra_ready", bus.cmd_ready_o, 1);
    rst = 1'b0;
    bus.pReady_i = 1'b1;
    step(5);
    check("ra_noretry", bus.pSel_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
